// File: rtl/hum_pkg.sv
// Shared types and default sizes for the humidity sampling sequencer.
package hum_pkg;

    localparam int HUM_DATA_W    = 16;
    localparam int HUM_PERIOD_W  = 8;
    localparam int HUM_TIMEOUT_S = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_PERIOD,
        ST_REQ,
        ST_WAIT_DATA,
        ST_UPDATE
    } hum_state_e;

endpackage

// File: rtl/hum_sample_ctrl_avg4.sv
// hum_avg4: 4-entry moving-average window; the first push after a clear fills every slot.
module hum_avg4 #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              i_clr,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_avg
);

    logic [DATA_W-1:0] r_win [4];
    logic              r_filled;
    logic [DATA_W+1:0] w_ext [4];
    logic [DATA_W+1:0] w_sum;

    always_ff @(posedge clk) begin
        if (srst || i_clr) begin
            r_filled <= 1'b0;
            for (int i = 0; i < 4; i++) r_win[i] <= '0;
        end else if (i_push) begin
            r_filled <= 1'b1;
            r_win[0] <= i_data;
            for (int i = 1; i < 4; i++) r_win[i] <= r_filled ? r_win[i-1] : i_data;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_ext
        assign w_ext[gi] = {2'b00, r_win[gi]};
    end

    assign w_sum = w_ext[0] + w_ext[1] + w_ext[2] + w_ext[3];
    assign o_avg = w_sum[DATA_W+1:2];

endmodule

// File: rtl/hum_sample_ctrl.sv
// Humidity sampling sequencer: periodic sensor request, capture, alarm and timeout.
// Define HUM_AVG_EN to publish a 4-sample moving average instead of the raw sample.
module hum_sample_ctrl
    import hum_pkg::*;
#(
    parameter int DATA_W    = HUM_DATA_W,
    parameter int PERIOD_W  = HUM_PERIOD_W,
    parameter int TIMEOUT_S = HUM_TIMEOUT_S
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic                ctrl_en,
    input  logic [PERIOD_W-1:0] period_s,
    input  logic [DATA_W-1:0]   hum_thr_hi,
    input  logic [DATA_W-1:0]   hum_thr_lo,
    input  logic                timeout_clr,
    input  logic                count_eq_1s,
    output logic                hum_counter_en,
    output logic                hum_counter_clr,
    output logic                meas_req,
    input  logic                meas_ack,
    input  logic [DATA_W-1:0]   meas_data,
    output logic [DATA_W-1:0]   hum_data,
    output logic                hum_data_vld,
    output logic                hum_alarm,
    output logic                meas_timeout
);

    localparam int TO_W  = $clog2(TIMEOUT_S + 1);
    localparam int CNT_W = (PERIOD_W > TO_W) ? PERIOD_W : TO_W;
    localparam logic [CNT_W:0] TO_LIM = (CNT_W+1)'(TIMEOUT_S);

    hum_state_e        r_state, w_next;
    logic [CNT_W-1:0]  r_sec_cnt, w_sec_next;
    logic [CNT_W:0]    w_sec_inc, w_period_eff;
    logic              r_meas_req, w_req_next;
    logic              r_vld, r_alarm, r_timeout;
    logic [DATA_W-1:0] r_hum_data, w_proc;
    logic              w_cnt_en, w_cnt_clr, w_capture, w_to_set, w_publish;

    assign w_sec_inc    = {1'b0, r_sec_cnt} + (CNT_W+1)'(1);
    assign w_period_eff = (period_s == '0) ? (CNT_W+1)'(1) : (CNT_W+1)'(period_s);

    always_comb begin
        w_next     = r_state;
        w_sec_next = r_sec_cnt;
        w_req_next = r_meas_req;
        w_cnt_en   = 1'b0;
        w_cnt_clr  = 1'b0;
        w_capture  = 1'b0;
        w_to_set   = 1'b0;
        w_publish  = 1'b0;
        if (!ctrl_en) begin
            // Abort from any state; a late ack is simply not looked at in IDLE.
            w_next     = ST_IDLE;
            w_sec_next = '0;
            w_req_next = 1'b0;
            w_cnt_clr  = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cnt_clr  = 1'b1;
                    w_sec_next = '0;
                    w_next     = ST_WAIT_PERIOD;
                end
                ST_WAIT_PERIOD: begin
                    w_cnt_en = 1'b1;
                    if (count_eq_1s) begin
                        w_cnt_clr = 1'b1;
                        if (w_sec_inc >= w_period_eff) begin
                            w_sec_next = '0;
                            w_req_next = 1'b1;
                            w_next     = ST_REQ;
                        end else begin
                            w_sec_next = w_sec_inc[CNT_W-1:0];
                        end
                    end
                end
                ST_REQ: begin
                    w_req_next = 1'b1;
                    w_sec_next = '0;
                    w_next     = ST_WAIT_DATA;
                end
                ST_WAIT_DATA: begin
                    w_cnt_en = 1'b1;
                    // Ack is checked first so it beats a coincident final second.
                    if (meas_ack) begin
                        w_capture  = 1'b1;
                        w_req_next = 1'b0;
                        w_next     = ST_UPDATE;
                    end else if (count_eq_1s) begin
                        if (w_sec_inc >= TO_LIM) begin
                            w_to_set   = 1'b1;
                            w_req_next = 1'b0;
                            w_sec_next = '0;
                            w_next     = ST_WAIT_PERIOD;
                        end else begin
                            w_sec_next = w_sec_inc[CNT_W-1:0];
                        end
                    end
                end
                ST_UPDATE: begin
                    w_publish  = 1'b1;
                    w_sec_next = '0;
                    w_next     = ST_WAIT_PERIOD;
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

`ifdef HUM_AVG_EN
    hum_avg4 #(.DATA_W(DATA_W)) u_avg (
        .clk    (pclk),
        .srst   (preset),
        .i_clr  (r_state == ST_IDLE),
        .i_push (w_capture),
        .i_data (meas_data),
        .o_avg  (w_proc)
    );
`else
    logic [DATA_W-1:0] r_sample;

    always_ff @(posedge pclk) begin
        if (preset)         r_sample <= '0;
        else if (w_capture) r_sample <= meas_data;
    end

    assign w_proc = r_sample;
`endif

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state    <= ST_IDLE;
            r_sec_cnt  <= '0;
            r_meas_req <= 1'b0;
            r_vld      <= 1'b0;
            r_alarm    <= 1'b0;
            r_timeout  <= 1'b0;
            r_hum_data <= '0;
        end else begin
            r_state    <= w_next;
            r_sec_cnt  <= w_sec_next;
            r_meas_req <= w_req_next;
            r_vld      <= w_publish;
            if (w_publish) begin
                r_hum_data <= w_proc;
                if (w_proc > hum_thr_hi)      r_alarm <= 1'b1;
                else if (w_proc < hum_thr_lo) r_alarm <= 1'b0;
            end
            if (w_to_set)         r_timeout <= 1'b1;
            else if (timeout_clr) r_timeout <= 1'b0;
        end
    end

    // Counter strobes are combinational; hold them low while reset is asserted.
    assign hum_counter_en  = w_cnt_en  & ~preset;
    assign hum_counter_clr = w_cnt_clr & ~preset;
    assign meas_req        = r_meas_req;
    assign hum_data        = r_hum_data;
    assign hum_data_vld    = r_vld;
    assign hum_alarm       = r_alarm;
    assign meas_timeout    = r_timeout;

endmodule

// File: tb/tb_hum_sample_ctrl.sv
// Randomized scoreboard bench for hum_sample_ctrl with a behavioural sample/alarm model.
module tb_hum_sample_ctrl;

    localparam int DW = 16;
    localparam int PW = 8;
    localparam int TO = 2;
    localparam int N  = 10;

    logic          pclk = 1'b0;
    logic          preset = 1'b1;
    logic          ctrl_en = 1'b0;
    logic [PW-1:0] period_s = '0;
    logic [DW-1:0] thr_hi = '1;
    logic [DW-1:0] thr_lo = '0;
    logic          timeout_clr = 1'b0;
    logic          count_eq_1s;
    logic          hum_counter_en, hum_counter_clr, meas_req;
    logic          meas_ack = 1'b0;
    logic [DW-1:0] meas_data = '0;
    logic [DW-1:0] hum_data;
    logic          hum_data_vld, hum_alarm, meas_timeout;

    hum_sample_ctrl #(.DATA_W(DW), .PERIOD_W(PW), .TIMEOUT_S(TO)) dut (
        .pclk(pclk), .preset(preset), .ctrl_en(ctrl_en), .period_s(period_s),
        .hum_thr_hi(thr_hi), .hum_thr_lo(thr_lo), .timeout_clr(timeout_clr),
        .count_eq_1s(count_eq_1s), .hum_counter_en(hum_counter_en),
        .hum_counter_clr(hum_counter_clr), .meas_req(meas_req), .meas_ack(meas_ack),
        .meas_data(meas_data), .hum_data(hum_data), .hum_data_vld(hum_data_vld),
        .hum_alarm(hum_alarm), .meas_timeout(meas_timeout)
    );

    always #5 pclk = ~pclk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int tcnt  = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    // Stub of the 1-second timer: terminal count every N enabled cycles.
    always @(posedge pclk) begin
        if (preset || hum_counter_clr) tcnt <= 0;
        else if (hum_counter_en)       tcnt <= (tcnt == N-1) ? 0 : tcnt + 1;
    end
    assign count_eq_1s = hum_counter_en && (tcnt == N-1);

    typedef struct {
        logic [DW-1:0] data;
        logic          alarm;
        int            at;
    } exp_t;

    exp_t          sb[$];
    exp_t          e;
    logic          m_alarm = 1'b0;
    logic [DW-1:0] m_last  = '0;
`ifdef HUM_AVG_EN
    int            m_hist[$];
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] model_proc(input logic [DW-1:0] d);
`ifdef HUM_AVG_EN
        int s;
        if (m_hist.size() == 0) begin
            repeat (4) m_hist.push_back(int'(d));
        end else begin
            m_hist.push_back(int'(d));
            void'(m_hist.pop_front());
        end
        s = 0;
        foreach (m_hist[i]) s += m_hist[i];
        return DW'(s / 4);
`else
        return d;
`endif
    endfunction

    function automatic void model_idle();
`ifdef HUM_AVG_EN
        m_hist.delete();
`endif
    endfunction

    // Called in the cycle the ack is presented; vld is due two clocks later.
    task automatic push_exp(input logic [DW-1:0] d);
        exp_t x;
        x.data = model_proc(d);
        if (x.data > thr_hi)      m_alarm = 1'b1;
        else if (x.data < thr_lo) m_alarm = 1'b0;
        m_last  = x.data;
        x.alarm = m_alarm;
        x.at    = cyc + 2;
        sb.push_back(x);
        $display("txn ack data=%0d expect pub=%0d alarm=%0b at cycle %0d", d, x.data, x.alarm, x.at);
    endtask

    always @(negedge pclk) begin
        if (!preset && hum_data_vld) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_vld: got vld=1 data=%0h want no vld (cycle %0d)", hum_data, cyc);
            end else begin
                e = sb.pop_front();
                chk("vld_data", 32'(hum_data), 32'(e.data));
                chk("vld_alarm", 32'(hum_alarm), 32'(e.alarm));
                chk("vld_latency", 32'(cyc), 32'(e.at));
            end
        end
    end

    // Evaluates the current cycle first so no pulse before the first negedge is lost.
    task automatic wait_req(output int pulses, output bit ok);
        pulses = 0;
        ok     = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (meas_req) begin
                ok = 1'b1;
                break;
            end
            if (count_eq_1s) pulses++;
            @(negedge pclk);
        end
        chk("req_seen", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            @(negedge pclk);
            #1;
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL missing_vld: got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic txn(input int per, input logic [DW-1:0] d, input int dly, input bit chk_p);
        int p;
        bit ok;
        period_s = PW'(per);
        wait_req(p, ok);
        if (chk_p) chk("req_pulses", 32'(p), 32'((per == 0) ? 1 : per));
        repeat (dly) @(posedge pclk);
        @(posedge pclk);
        #1;
        meas_ack  = 1'b1;
        meas_data = d;
        push_exp(d);
        @(posedge pclk);
        #1;
        meas_ack = 1'b0;
        drain();
        chk("req_low_after_ack", 32'(meas_req), 32'd0);
    endtask

    initial begin
        int p;
        bit ok;
        logic [DW-1:0] d;

        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("rst_req", 32'(meas_req), 32'd0);
        chk("rst_data", 32'(hum_data), 32'd0);
        chk("rst_vld", 32'(hum_data_vld), 32'd0);
        chk("rst_alarm", 32'(hum_alarm), 32'd0);
        chk("rst_timeout", 32'(meas_timeout), 32'd0);
        chk("rst_cnt_en", 32'(hum_counter_en), 32'd0);
        chk("rst_cnt_clr", 32'(hum_counter_clr), 32'd0);
        @(posedge pclk);
        #1;
        preset = 1'b0;
        @(negedge pclk);
        chk("idle_cnt_clr", 32'(hum_counter_clr), 32'd1);
        chk("idle_cnt_en", 32'(hum_counter_en), 32'd0);

        // Basic measurement, then period 0 behaving as 1.
        @(posedge pclk);
        #1;
        ctrl_en = 1'b1;
        txn(3, 16'h1234, 5, 1'b1);
        chk("hum_data_1234", 32'(hum_data), 32'h1234);
        txn(0, 16'h0042, 2, 1'b1);

        // Sensor never answers: timeout after TO seconds in WAIT_DATA.
        period_s = 8'd1;
        wait_req(p, ok);
        p = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge pclk);
            if (!meas_req) break;
            if (count_eq_1s) p++;
        end
        $display("txn timeout after %0d pulses", p);
        chk("to_pulses", 32'(p), 32'(TO));
        chk("to_flag", 32'(meas_timeout), 32'd1);
        chk("to_data_hold", 32'(hum_data), 32'(m_last));
        @(posedge pclk);
        #1;
        timeout_clr = 1'b1;
        @(posedge pclk);
        #1;
        timeout_clr = 1'b0;
        @(negedge pclk);
        chk("to_cleared", 32'(meas_timeout), 32'd0);

        // Ack coincident with the final timeout second: ack wins.
        wait_req(p, ok);
        p = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge pclk);
            if (count_eq_1s) p++;
            if (p == TO) begin
                d         = 16'd777;
                meas_ack  = 1'b1;
                meas_data = d;
                push_exp(d);
                break;
            end
        end
        @(posedge pclk);
        #1;
        meas_ack = 1'b0;
        drain();
        chk("race_no_timeout", 32'(meas_timeout), 32'd0);

        // Hysteresis thresholds.
        thr_hi = 16'd600;
        thr_lo = 16'd400;
        txn(1, 16'd700, 1, 1'b1);
        txn(1, 16'd500, 3, 1'b1);
        txn(1, 16'd300, 0, 1'b1);

        // Abort while waiting for data; the late ack must be ignored.
        wait_req(p, ok);
        repeat (3) @(posedge pclk);
        #1;
        ctrl_en = 1'b0;
        @(posedge pclk);
        #1;
        meas_ack  = 1'b1;
        meas_data = 16'hBEEF;
        @(posedge pclk);
        #1;
        meas_ack = 1'b0;
        @(negedge pclk);
        $display("txn abort: ack ignored");
        chk("abort_cnt_clr", 32'(hum_counter_clr), 32'd1);
        chk("abort_cnt_en", 32'(hum_counter_en), 32'd0);
        chk("abort_req", 32'(meas_req), 32'd0);
        chk("abort_data_hold", 32'(hum_data), 32'(m_last));
        repeat (5) @(negedge pclk);
        model_idle();

        // Fresh history after IDLE: ramp of four samples.
        thr_hi = '1;
        thr_lo = '0;
        @(posedge pclk);
        #1;
        ctrl_en = 1'b1;
        txn(1, 16'd100, 1, 1'b1);
        txn(1, 16'd200, 1, 1'b1);
        txn(1, 16'd300, 1, 1'b1);
        txn(1, 16'd400, 1, 1'b1);

        for (int k = 0; k < 16; k++) begin
            thr_hi = DW'($urandom_range(1000));
            thr_lo = DW'($urandom_range(1000));
            d = (k % 4 == 3) ? DW'($urandom) : DW'($urandom_range(1200));
            txn(int'($urandom_range(3)), d, int'($urandom_range(12)), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
